// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder placed between the program counter and the
//   decoder. It accepts one byte fetch address at a time and returns the 32-bit
//   instruction word after WAIT_STATES extra cycles. The instruction store is
//   loaded through a separate program-write port. A flush (branch/jump
//   redirect) abandons any in-flight fetch.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready
//   && !flush. A response transfers on a rising edge where resp_valid &&
//   resp_ready && !flush. While resp_valid is high, resp_data and resp_err
//   hold steady until the response transfers or a flush removes it.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   address               byte fetch address
//   req_valid/req_ready   fetch request handshake
//   resp_valid/resp_ready response handshake
//   resp_data, resp_err   instruction word (0 on error), error flag
//   flush                 abort in-flight fetch, highest priority
//   prog_we, prog_addr,   program write of one word (word index);
//   prog_data             out-of-range indices are ignored
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        flush,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // state is kept as a plain named signal so checkers can bind to it.
    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [31:0] data_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          fetch_err;
    logic [AW-1:0] word_idx;

    assign accept = (state == S_IDLE) && req_valid && !flush;

    // The full 30-bit word index is range-checked so that high address bits
    // can never alias onto a valid word.
    assign fetch_err = (address[1:0] != 2'b00) ||
                       ({2'b00, address[31:2]} >= 32'(DEPTH));
    assign word_idx  = address[AW+1:2];

    always_comb begin
        state_next = state;
        count_next = count;
        if (flush) begin
            state_next = S_IDLE;
            count_next = 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (WAIT_STATES == 0) begin
                            state_next = S_RESP;
                            count_next = 4'd0;
                        end else begin
                            state_next = S_WAIT;
                            count_next = 4'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    if (count <= 4'd1) begin
                        state_next = S_RESP;
                        count_next = 4'd0;
                    end else begin
                        count_next = count - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_next = S_IDLE;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    count_next = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= 4'd0;
            data_q <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            // The word is captured at accept, so a later program write to the
            // same word (or one in the same cycle) does not change this fetch.
            if (accept) begin
                data_q <= fetch_err ? 32'd0 : mem[word_idx];
                err_q  <= fetch_err;
            end
        end
    end

    // Instruction store: not cleared by reset.
    always_ff @(posedge clk) begin
        if (prog_we && (prog_addr < 32'(DEPTH))) begin
            mem[prog_addr[AW-1:0]] <= prog_data;
        end
    end

    assign req_ready  = (state == S_IDLE) && !rst;
    assign resp_valid = (state == S_RESP);
    assign resp_data  = data_q;
    assign resp_err   = err_q;

endmodule
